// File: rtl/spin_fifo_drainer_pkg.sv
// Shared types and defaults for the spin FIFO drainer.
//   drain_state_e : drainer FSM states
//   DEF_*         : default parameter values
//   idx_width()   : word-index width for a given word count (never below 1)
package spin_fifo_drainer_pkg;

  localparam int unsigned DEF_DATASPIN = 256;
  localparam int unsigned DEF_WORD_W   = 32;
  localparam int unsigned DEF_CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2,
    STOP = 2'd3
  } drain_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spin_fifo_drainer_if.sv
// Handshake bundle between the spin FIFO, the drainer and the word consumer.
//   spin_pop_valid_i / spin_pop_i / spin_pop_ready_o : FIFO pop handshake
//   word_valid_o / word_o / word_idx_o / word_last_o / word_ready_i : word stream
// master = drainer side, slave = FIFO + consumer side.
interface spin_fifo_drainer_if
  import spin_fifo_drainer_pkg::*;
#(
  parameter int unsigned DATASPIN = DEF_DATASPIN,
  parameter int unsigned WORD_W   = DEF_WORD_W,
  parameter int unsigned IDX_W    = idx_width(DATASPIN / WORD_W)
);

  logic                spin_pop_valid_i;
  logic [DATASPIN-1:0] spin_pop_i;
  logic                spin_pop_ready_o;
  logic                word_valid_o;
  logic [WORD_W-1:0]   word_o;
  logic [IDX_W-1:0]    word_idx_o;
  logic                word_last_o;
  logic                word_ready_i;

  modport master (
    input  spin_pop_valid_i, spin_pop_i, word_ready_i,
    output spin_pop_ready_o, word_valid_o, word_o, word_idx_o, word_last_o
  );

  modport slave (
    output spin_pop_valid_i, spin_pop_i, word_ready_i,
    input  spin_pop_ready_o, word_valid_o, word_o, word_idx_o, word_last_o
  );

endinterface

// File: rtl/spin_fifo_drainer.sv
// Read-side partner of the spin FIFO. Pops one DATASPIN-bit spin vector at a
// time, serialises it LSB-first into NUM_WORDS words of WORD_W bits, counts
// drained entries and pulses cmpt_stop_o for one cycle when the session
// target is reached (target 0 = unlimited).
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   en_i           : enable; low masks handshakes and holds all state
//   flush_i        : synchronous abort to IDLE, clears count and data
//   start_i        : arm a session (IDLE only); target_i sampled here
//   bus            : pop + word stream handshakes (master modport)
//   cmpt_stop_o    : one-cycle pulse when target reached
//   busy_o         : FSM not in IDLE
//   done_count_o   : entries fully drained this session
module spin_fifo_drainer
  import spin_fifo_drainer_pkg::*;
#(
  parameter int unsigned DATASPIN = DEF_DATASPIN,
  parameter int unsigned WORD_W   = DEF_WORD_W,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                flush_i,
  input  logic                start_i,
  input  logic [CNT_W-1:0]    target_i,
  spin_fifo_drainer_if.master bus,
  output logic                cmpt_stop_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    done_count_o
);

  localparam int unsigned NUM_WORDS = DATASPIN / WORD_W;
  localparam int unsigned IDX_W     = idx_width(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  drain_state_e        r_state;
  logic [DATASPIN-1:0] r_shreg;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_target;

  logic             w_last;
  logic             w_pop_hs;
  logic             w_word_hs;
  logic             w_hit_target;
  logic [CNT_W-1:0] w_count_nxt;

  always_comb begin
    w_last      = (r_state == SEND) && (r_idx == LAST_IDX);
    w_pop_hs    = en_i && (r_state == WAIT) && bus.spin_pop_valid_i;
    w_word_hs   = en_i && (r_state == SEND) && bus.word_ready_i;
    w_count_nxt = (r_count == CNT_MAX) ? r_count : r_count + 1'b1;
    // Compared one bit wider so a saturated count can never alias a target.
    w_hit_target = (r_target != '0) &&
                   (({1'b0, r_count} + 1'b1) == {1'b0, r_target});
  end

  always_comb begin
    bus.spin_pop_ready_o = en_i && (r_state == WAIT);
    bus.word_valid_o     = en_i && (r_state == SEND);
    bus.word_o           = r_shreg[WORD_W-1:0];
    bus.word_idx_o       = r_idx;
    bus.word_last_o      = w_last;
    cmpt_stop_o          = (r_state == STOP);
    busy_o               = (r_state != IDLE);
    done_count_o         = r_count;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_idx    <= '0;
      r_count  <= '0;
      r_target <= '0;
    end else if (flush_i) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en_i && start_i) begin
            r_state  <= WAIT;
            r_target <= target_i;
            r_count  <= '0;
          end
        end
        WAIT: begin
          if (w_pop_hs) begin
            r_shreg <= bus.spin_pop_i;
            r_idx   <= '0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_word_hs) begin
            if (w_last) begin
              r_count <= w_count_nxt;
              r_state <= w_hit_target ? STOP : WAIT;
            end else begin
              r_shreg <= r_shreg >> WORD_W;
              r_idx   <= r_idx + 1'b1;
            end
          end
        end
        // Leaves even with en_i low so the pulse is always one cycle.
        STOP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spin_fifo_drainer.sv
module tb_spin_fifo_drainer;

  localparam int DS = 256;
  localparam int WW = 32;
  localparam int NW = DS / WW;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n, en, flush, start;
  logic [CW-1:0] target;
  logic          cmpt_stop, busy;
  logic [CW-1:0] done_count;

  spin_fifo_drainer_if #(.DATASPIN(DS), .WORD_W(WW)) sif ();

  spin_fifo_drainer #(.DATASPIN(DS), .WORD_W(WW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .flush_i(flush),
    .start_i(start), .target_i(target), .bus(sif),
    .cmpt_stop_o(cmpt_stop), .busy_o(busy), .done_count_o(done_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0b req=%0b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d req=%0d", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%08h req=%08h", name, act, exp);
    end
  endtask

  // Drive point: 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] slice(input logic [DS-1:0] d, input int j);
    return d[j*WW +: WW];
  endfunction

  function automatic logic [DS-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_valid"}, sif.word_valid_o, 1'b0);
    chk1({tag, "_ready"}, sif.spin_pop_ready_o, 1'b0);
    chkw({tag, "_word"}, sif.word_o, '0);
    chki({tag, "_idx"}, int'(sif.word_idx_o), 0);
    chk1({tag, "_last"}, sif.word_last_o, 1'b0);
    chk1({tag, "_stop"}, cmpt_stop, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chki({tag, "_count"}, int'(done_count), 0);
  endtask

  // ---------------- transaction-level reference model ----------------
  // Expected words queue up per accepted vector; completions, target hits
  // and pulse timing follow from word handshakes seen on the bus.
  logic [WW-1:0] q[$];
  int            pop_cycles[$];
  int            m_idx, m_comp, m_tgt, dut_stops, cyc;
  bit            m_active, m_stop_exp, m_pop_hs;

  task automatic observe();
    bit next_stop;
    next_stop = 1'b0;
    chk1("busy", busy, m_active);
    chk1("cmpt_stop", cmpt_stop, m_stop_exp);
    chki("done_count", int'(done_count), m_comp);
    chk1("pop_ready", sif.spin_pop_ready_o, en && m_active && !m_stop_exp && (q.size() == 0));
    chk1("word_valid", sif.word_valid_o, en && (q.size() != 0));
    if (cmpt_stop) dut_stops++;
    if (sif.word_valid_o && q.size() != 0) begin
      chkw("word", sif.word_o, q[0]);
      chki("word_idx", int'(sif.word_idx_o), m_idx);
      chk1("word_last", sif.word_last_o, m_idx == NW - 1);
      if (sif.word_ready_i) begin
        void'(q.pop_front());
        if (m_idx == NW - 1) begin
          m_idx = 0;
          m_comp++;
          if (m_tgt != 0 && m_comp == m_tgt) next_stop = 1'b1;
        end else begin
          m_idx++;
        end
      end
    end
    m_pop_hs = sif.spin_pop_valid_i && sif.spin_pop_ready_o;
    if (m_pop_hs) begin
      for (int j = 0; j < NW; j++) q.push_back(slice(sif.spin_pop_i, j));
      pop_cycles.push_back(cyc);
    end
    if (m_stop_exp) m_active = 1'b0;
    m_stop_exp = next_stop;
  endtask

  typedef struct {
    int          tgt;
    int          offer;
    int unsigned rdy_pct;
    int unsigned en_pct;
    int unsigned vld_pct;
    int          exp_cnt;
    int          exp_stops;
  } sess_t;

  task automatic run_session(input sess_t s);
    int  offered, idle;
    bit  done;
    m_tgt = s.tgt;
    target = CW'(s.tgt);
    en = 1'b1; flush = 1'b0; start = 1'b1;
    sif.word_ready_i = 1'b0; sif.spin_pop_valid_i = 1'b0;
    step();
    start = 1'b0;
    q.delete(); pop_cycles.delete();
    m_idx = 0; m_comp = 0; dut_stops = 0;
    m_active = 1'b1; m_stop_exp = 1'b0;
    offered = 0; idle = 0; done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      cyc = c;
      en = ($urandom_range(99) < s.en_pct);
      sif.word_ready_i = ($urandom_range(99) < s.rdy_pct);
      target = CW'($urandom);
      if (!sif.spin_pop_valid_i && offered < s.offer && $urandom_range(99) < s.vld_pct) begin
        sif.spin_pop_valid_i = 1'b1;
        sif.spin_pop_i = rand_vec();
      end
      #1;
      observe();
      if (m_pop_hs) offered++;
      step();
      if (m_pop_hs) sif.spin_pop_valid_i = 1'b0;
      if (!m_active) done = 1'b1;
      else if (offered == s.offer && q.size() == 0 && !m_stop_exp) begin
        idle++;
        if (idle > 3) done = 1'b1;
      end
    end
    chk1("sess_timeout", done, 1'b1);
    sif.spin_pop_valid_i = 1'b0;
    en = 1'b1;
    #1;
    chk1("sess_busy", busy, s.exp_stops == 0);
    chki("sess_count", int'(done_count), s.exp_cnt);
    chki("sess_stops", dut_stops, s.exp_stops);
    if (s.rdy_pct == 100 && s.en_pct == 100 && s.vld_pct == 100)
      for (int i = 1; i < pop_cycles.size(); i++)
        chki("pop_spacing", pop_cycles[i] - pop_cycles[i-1], NW + 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk1("sess_flush_busy", busy, 1'b0);
    chki("sess_flush_count", int'(done_count), 0);
    step();
  endtask

  sess_t sessions[6];
  logic [DS-1:0] d, d2;
  logic [WW-1:0] e;

  initial begin
    sessions[0] = '{tgt: 3, offer: 3,  rdy_pct: 100, en_pct: 100, vld_pct: 100, exp_cnt: 3,  exp_stops: 1};
    sessions[1] = '{tgt: 0, offer: 10, rdy_pct: 100, en_pct: 100, vld_pct: 100, exp_cnt: 10, exp_stops: 0};
    sessions[2] = '{tgt: 2, offer: 4,  rdy_pct: 50,  en_pct: 100, vld_pct: 70,  exp_cnt: 2,  exp_stops: 1};
    sessions[3] = '{tgt: 4, offer: 4,  rdy_pct: 50,  en_pct: 80,  vld_pct: 60,  exp_cnt: 4,  exp_stops: 1};
    sessions[4] = '{tgt: 5, offer: 3,  rdy_pct: 60,  en_pct: 90,  vld_pct: 100, exp_cnt: 3,  exp_stops: 0};
    sessions[5] = '{tgt: 1, offer: 1,  rdy_pct: 30,  en_pct: 70,  vld_pct: 50,  exp_cnt: 1,  exp_stops: 1};

    rst_n = 1'b0; en = 1'b0; flush = 1'b0; start = 1'b0; target = '0;
    sif.spin_pop_valid_i = 1'b0; sif.spin_pop_i = '0; sif.word_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    en = 1'b1;
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Known byte pattern, target 1: eight LSB-first words then one stop pulse.
    for (int k = 0; k < DS / 8; k++) d[k*8 +: 8] = 8'(k + 1);
    target = CW'(1); start = 1'b1;
    step();
    start = 1'b0;
    sif.spin_pop_i = d; sif.spin_pop_valid_i = 1'b1;
    #1;
    chk1("t1_ready", sif.spin_pop_ready_o, 1'b1);
    step();
    sif.spin_pop_valid_i = 1'b0; sif.word_ready_i = 1'b1;
    for (int j = 0; j < NW; j++) begin
      e = {8'(4*j + 4), 8'(4*j + 3), 8'(4*j + 2), 8'(4*j + 1)};
      #1;
      chk1("t1_valid", sif.word_valid_o, 1'b1);
      chkw("t1_word", sif.word_o, e);
      chki("t1_idx", int'(sif.word_idx_o), j);
      chk1("t1_last", sif.word_last_o, j == NW - 1);
      chk1("t1_nostop", cmpt_stop, 1'b0);
      step();
    end
    #1;
    chk1("t1_stop", cmpt_stop, 1'b1);
    chk1("t1_stop_busy", busy, 1'b1);
    chki("t1_stop_count", int'(done_count), 1);
    step();
    #1;
    chk1("t1_stop_once", cmpt_stop, 1'b0);
    chk1("t1_idle", busy, 1'b0);
    chki("t1_count_hold", int'(done_count), 1);
    sif.word_ready_i = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_session(sessions[i]);

    // en_i low for 5 cycles while word 3 is presented.
    d = rand_vec();
    target = '0; start = 1'b1;
    step();
    start = 1'b0;
    sif.spin_pop_i = d; sif.spin_pop_valid_i = 1'b1;
    step();
    sif.spin_pop_valid_i = 1'b0; sif.word_ready_i = 1'b1;
    repeat (3) step();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk1("t4_valid_masked", sif.word_valid_o, 1'b0);
      chk1("t4_ready_masked", sif.spin_pop_ready_o, 1'b0);
      chki("t4_idx_hold", int'(sif.word_idx_o), 3);
      chkw("t4_word_hold", sif.word_o, slice(d, 3));
      step();
    end
    en = 1'b1;
    for (int j = 3; j < NW; j++) begin
      #1;
      chk1("t4_valid", sif.word_valid_o, 1'b1);
      chki("t4_idx", int'(sif.word_idx_o), j);
      chkw("t4_word", sif.word_o, slice(d, j));
      step();
    end
    #1;
    chki("t4_count", int'(done_count), 1);
    chk1("t4_wait_ready", sif.spin_pop_ready_o, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Flush at idx 5 of the second entry, coincident with a word handshake.
    d = rand_vec(); d2 = rand_vec();
    target = CW'(3); start = 1'b1; sif.word_ready_i = 1'b0;
    step();
    start = 1'b0;
    sif.spin_pop_i = d; sif.spin_pop_valid_i = 1'b1;
    step();
    sif.spin_pop_valid_i = 1'b0; sif.word_ready_i = 1'b1;
    repeat (NW) step();
    sif.spin_pop_i = d2; sif.spin_pop_valid_i = 1'b1;
    step();
    sif.spin_pop_valid_i = 1'b0;
    repeat (5) step();
    #1;
    chki("t5_idx", int'(sif.word_idx_o), 5);
    chki("t5_count_pre", int'(done_count), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk1("t5_busy", busy, 1'b0);
    chki("t5_count", int'(done_count), 0);
    chk1("t5_stop", cmpt_stop, 1'b0);
    chk1("t5_valid", sif.word_valid_o, 1'b0);
    step();
    #1;
    chk1("t5_stop_after", cmpt_stop, 1'b0);
    start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    #1;
    chk1("t5_start_flush", busy, 1'b0);
    step();

    // Reset while mid-SEND with a nonzero count.
    d = rand_vec(); d2 = rand_vec();
    target = '0; start = 1'b1;
    step();
    start = 1'b0;
    sif.spin_pop_i = d; sif.spin_pop_valid_i = 1'b1;
    step();
    sif.spin_pop_valid_i = 1'b0;
    repeat (NW) step();
    sif.spin_pop_i = d2; sif.spin_pop_valid_i = 1'b1;
    step();
    sif.spin_pop_valid_i = 1'b0;
    repeat (2) step();
    #1;
    chki("t6_count_pre", int'(done_count), 1);
    chk1("t6_valid_pre", sif.word_valid_o, 1'b1);
    rst_n = 1'b0;
    step();
    chk_all_zero("t6_reset");
    rst_n = 1'b1;
    sif.word_ready_i = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
